shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-add multiplier; the multiply counterpart of the restoring-division unit in the arithmetic block set.
- Controller and datapath are in one module. Uses the same Start/FINISH handshake and IDLE/INIT/LOAD/INPUTCHECK style of flow as the divider.
- Consumes two WIDTH-bit operands and produces a 2*WIDTH-bit product, plus overflow and zero-operand flags.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- CLK    input   1          clock; all state changes on its rising edge.
- RST    input   1          reset, asynchronous, active-high.
- Start  input   1          start request; operation launches on its falling edge (see handshake).
- A      input   WIDTH      multiplicand, sampled in LOAD.
- B      input   WIDTH      multiplier, sampled in LOAD.
- P      output  2*WIDTH    product register.
- FINISH output  1          one-cycle completion pulse.
- BUSY   output  1          high in every state except IDLE.
- OV     output  1          product does not fit in WIDTH bits (P[2W-1:W] != 0).
- ZERO   output  1          zero-operand shortcut was taken.

Behaviour:
- Reset (RST high, async): state=IDLE; P=0, OV=0, ZERO=0, FINISH=0, BUSY=0; internal acc, mreg, areg and cnt all 0.
- Internal registers: areg[W-1:0], acc[W:0] (upper half plus carry), mreg[W-1:0] (lower half/multiplier), cnt (ceil(log2(W+1)) bits).
- States and transitions:
  - IDLE: Start=1 -> INIT; else stay in IDLE.
  - INIT: clear acc, mreg, cnt, P, OV and ZERO. Start=1 -> stay in INIT; Start=0 -> LOAD.
  - LOAD: areg<=A; mreg<=B; acc<=0; cnt<=0 -> INPUTCHECK.
  - INPUTCHECK: if areg==0 or mreg==0: ZERO<=1 -> END. Otherwise -> ADD.
  - ADD: if mreg[0]: acc<=acc[W-1:0]+areg, with carry into acc[W]. Else acc unchanged. -> SHIFT.
  - SHIFT: {acc,mreg}<={1'b0,acc,mreg}>>1; cnt<=cnt+1 -> COCHECK.
  - COCHECK: cnt==WIDTH -> END; else -> ADD.
  - END: FINISH=1 for this cycle only. P<={acc[W-1:0],mreg}, or 0 on the zero path. OV<=(acc[W-1:0]!=0). -> IDLE.
- FINISH and BUSY are Moore outputs, decoded combinationally from state only.
- Latency, with LOAD as cycle 0:
  - Normal path: FINISH high in cycle 3*WIDTH+2 (cycle 26 for W=8).
  - Zero-operand path: FINISH high in cycle 2.
- P, OV and ZERO hold their values from END until the next INIT clears them. They are valid whenever in IDLE after a completed operation.
- Start while BUSY, in any state other than IDLE and INIT, is ignored; no restart and no effect on the result.
- Start held high indefinitely keeps the FSM in INIT with BUSY=1.
- Operands change after LOAD: no effect on the result.
- Arithmetic width rules:
  - The add carry is never lost; acc has W+1 bits and the shift moves the carry into acc[W-1].
  - Final acc[W] is always 0.
- RST mid-operation: immediate return to IDLE with all outputs 0; the next Start runs normally.
- Undefined state encodings -> IDLE.

Test Plan:
- W=8. Pulse Start (2 cycles high, then low); A=13, B=11 -> FINISH in cycle 26 after LOAD; P=143 (0x008F), OV=0, ZERO=0; BUSY high from INIT through END.
- A=255, B=255 -> P=0xFE01, OV=1, ZERO=0. Then A=16, B=16 -> P=0x0100, OV=1 (boundary case).
- A=0, B=77 -> FINISH in cycle 2 after LOAD; P=0, ZERO=1, OV=0. Repeat with A=77, B=0 -> same response.
- During a 200*3 run: toggle Start high for 3 cycles mid-loop and change A/B -> result still P=600 (0x0258), OV=1; FINISH timing unchanged.
- Assert RST at cycle 10 of a 100*100 run -> all outputs 0, IDLE next edge. A fresh 100*100 run then gives P=10000 (0x2710), OV=1.
- Back-to-back: 7*9, then 1*1 -> P=63, then P=1. On the second Start, INIT clears P/OV/ZERO to 0 before LOAD. FINISH is exactly one cycle wide each time.

Source files
------------

// File: rtl/shift_add_multiplier_if.sv
// Purpose : operand/result bundle for the sequential shift-add multiplier.
// Latency : none (wires only).
// Backpr. : none; the Start/FINISH handshake carries all flow control.
// Signals : Start, A, B driven by the requester (master);
//           P, FINISH, BUSY, OV, ZERO driven by the multiplier (slave).
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   Start;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     P;
    logic                   FINISH;
    logic                   BUSY;
    logic                   OV;
    logic                   ZERO;

    // Requester side: launches operations and reads back the result.
    modport master (
        output Start,
        output A,
        output B,
        input  P,
        input  FINISH,
        input  BUSY,
        input  OV,
        input  ZERO
    );

    // Multiplier side.
    modport slave (
        input  Start,
        input  A,
        input  B,
        output P,
        output FINISH,
        output BUSY,
        output OV,
        output ZERO
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Purpose : sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency : FINISH in cycle 3*WIDTH+2 after LOAD (cycle 2 on the zero-operand path).
// Backpr. : none; Start is ignored while busy past INIT, result held until next INIT.
// Ports   : CLK, RST (async, active-high) plus bus (slave modport):
//           Start in, A/B operands in, P product out, FINISH one-cycle done pulse,
//           BUSY high outside IDLE, OV product exceeds WIDTH bits, ZERO shortcut taken.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    shift_add_multiplier_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INIT       = 4'd1,
        S_LOAD       = 4'd2,
        S_INPUTCHECK = 4'd3,
        S_ADD        = 4'd4,
        S_SHIFT      = 4'd5,
        S_COCHECK    = 4'd6,
        S_END        = 4'd7
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       areg_q;     // latched multiplicand
    logic [WIDTH:0]         acc_q;      // upper product half plus carry bit
    logic [WIDTH-1:0]       mreg_q;     // multiplier, becomes lower product half
    logic [CW-1:0]          cnt_q;      // completed add/shift iterations
    logic [2*WIDTH-1:0]     p_q;
    logic                   ov_q;
    logic                   zero_q;

    // Partial-product add; the extra MSB catches the carry so it is never lost.
    logic [WIDTH:0]         sum_d;
    assign sum_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, areg_q};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            areg_q  <= '0;
            acc_q   <= '0;
            mreg_q  <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        state_q <= S_INIT;
                    end
                end

                // Operation launches on the falling edge of Start: wait here
                // for as long as Start is held.
                S_INIT: begin
                    acc_q  <= '0;
                    mreg_q <= '0;
                    cnt_q  <= '0;
                    p_q    <= '0;
                    ov_q   <= 1'b0;
                    zero_q <= 1'b0;
                    if (!bus.Start) begin
                        state_q <= S_LOAD;
                    end
                end

                // Operands are captured only here; later changes on A/B are ignored.
                S_LOAD: begin
                    areg_q  <= bus.A;
                    mreg_q  <= bus.B;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_INPUTCHECK;
                end

                S_INPUTCHECK: begin
                    if ((areg_q == '0) || (mreg_q == '0)) begin
                        zero_q  <= 1'b1;
                        state_q <= S_END;
                    end else begin
                        state_q <= S_ADD;
                    end
                end

                S_ADD: begin
                    if (mreg_q[0]) begin
                        acc_q <= sum_d;
                    end
                    state_q <= S_SHIFT;
                end

                // Shift the whole {acc, mreg} pair right by one: the carry in
                // acc[WIDTH] drops into acc[WIDTH-1], acc[0] into mreg's MSB.
                S_SHIFT: begin
                    acc_q   <= {1'b0, acc_q[WIDTH:1]};
                    mreg_q  <= {acc_q[0], mreg_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CW'(1);
                    state_q <= S_COCHECK;
                end

                S_COCHECK: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        state_q <= S_END;
                    end else begin
                        state_q <= S_ADD;
                    end
                end

                // On the zero path mreg still holds the untouched operand, so
                // the product is forced to zero explicitly.
                S_END: begin
                    p_q     <= zero_q ? '0 : {acc_q[WIDTH-1:0], mreg_q};
                    ov_q    <= (acc_q[WIDTH-1:0] != '0);
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign bus.FINISH = (state_q == S_END);
    assign bus.BUSY   = (state_q != S_IDLE);
    assign bus.P      = p_q;
    assign bus.OV     = ov_q;
    assign bus.ZERO   = zero_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        logic           ov;
        logic           zero;
        int             lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for FINISH. Called #1 after a
    // rising edge with Start low. Returns FINISH latency (cycles after LOAD,
    // -1 on timeout) and the result read one cycle later in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int start_cycles, input bit disturb,
                          output int lat, output logic [2*W-1:0] p,
                          output logic ov, output logic zero);
        int n;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        for (int i = 0; i < start_cycles; i++) begin
            @(posedge CLK); #1;
            check("busy_in_init", 32'(bus.BUSY), 32'd1);
        end
        bus.Start = 1'b0;
        n   = -1;
        lat = -1;
        while (lat < 0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
            if (n == 0) begin
                // INIT must have cleared the previous result before LOAD.
                check("init_clear_p", 32'(bus.P), 32'd0);
                check("init_clear_flags", {30'd0, bus.OV, bus.ZERO}, 32'd0);
            end
            if (bus.FINISH) lat = n;
            else check("busy_running", 32'(bus.BUSY), 32'd1);
            if (disturb && n == 10) begin
                bus.Start = 1'b1;
                bus.A     = 8'd5;
                bus.B     = 8'd7;
            end
            if (disturb && n == 13) bus.Start = 1'b0;
        end
        @(posedge CLK); #1;
        check("finish_one_cycle", 32'(bus.FINISH), 32'd0);
        check("idle_after_end", 32'(bus.BUSY), 32'd0);
        p    = bus.P;
        ov   = bus.OV;
        zero = bus.ZERO;
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat,
                                input logic [2*W-1:0] p, input logic ov, input logic zero);
        check({tag, "_lat"}, 32'(lat), 32'(v.lat));
        check({tag, "_P"}, 32'(p), 32'(v.p));
        check({tag, "_OV"}, 32'(ov), 32'(v.ov));
        check({tag, "_ZERO"}, 32'(zero), 32'(v.zero));
    endtask

    // Reference: plain integer multiply, no cycle modelling.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        int unsigned prod;
        prod   = int'(a) * int'(b);
        v.a    = a;
        v.b    = b;
        v.p    = prod[2*W-1:0];
        v.ov   = (prod >= (1 << W));
        v.zero = (a == 0) || (b == 0);
        v.lat  = v.zero ? 2 : 3 * W + 2;
        return v;
    endfunction

    vec_t           tbl[7];
    vec_t           v;
    int             lat;
    logic [2*W-1:0] p;
    logic           ov;
    logic           zero;

    initial begin
        tbl[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F, ov: 1'b0, zero: 1'b0, lat: 26};
        tbl[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01, ov: 1'b1, zero: 1'b0, lat: 26};
        tbl[2] = '{a: 8'd16,  b: 8'd16,  p: 16'h0100, ov: 1'b1, zero: 1'b0, lat: 26};
        tbl[3] = '{a: 8'd0,   b: 8'd77,  p: 16'h0000, ov: 1'b0, zero: 1'b1, lat: 2};
        tbl[4] = '{a: 8'd77,  b: 8'd0,   p: 16'h0000, ov: 1'b0, zero: 1'b1, lat: 2};
        tbl[5] = '{a: 8'd7,   b: 8'd9,   p: 16'd63,   ov: 1'b0, zero: 1'b0, lat: 26};
        tbl[6] = '{a: 8'd1,   b: 8'd1,   p: 16'd1,    ov: 1'b0, zero: 1'b0, lat: 26};

        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset state.
        #1;
        check("rst_P", 32'(bus.P), 32'd0);
        check("rst_OV", 32'(bus.OV), 32'd0);
        check("rst_ZERO", 32'(bus.ZERO), 32'd0);
        check("rst_FINISH", 32'(bus.FINISH), 32'd0);
        check("rst_BUSY", 32'(bus.BUSY), 32'd0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;

        // Directed vectors, run back to back.
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, 2, 1'b0, lat, p, ov, zero);
            check_result($sformatf("vec%0d", i), tbl[i], lat, p, ov, zero);
        end

        // Start and operands toggled mid-loop must not disturb 200*3.
        v = '{a: 8'd200, b: 8'd3, p: 16'h0258, ov: 1'b1, zero: 1'b0, lat: 26};
        run_op(8'd200, 8'd3, 2, 1'b1, lat, p, ov, zero);
        check_result("disturb", v, lat, p, ov, zero);

        // Start held high for a long time keeps the unit parked in INIT.
        run_op(8'd12, 8'd12, 20, 1'b0, lat, p, ov, zero);
        check_result("long_start", model(8'd12, 8'd12), lat, p, ov, zero);

        // Reset in cycle 10 of a 100*100 run.
        bus.A     = 8'd100;
        bus.B     = 8'd100;
        bus.Start = 1'b1;
        repeat (2) @(posedge CLK);
        #1 bus.Start = 1'b0;
        repeat (11) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("midrst_BUSY", 32'(bus.BUSY), 32'd0);
        check("midrst_FINISH", 32'(bus.FINISH), 32'd0);
        check("midrst_P", 32'(bus.P), 32'd0);
        check("midrst_flags", {30'd0, bus.OV, bus.ZERO}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("post_rst_idle", 32'(bus.BUSY), 32'd0);
        v = '{a: 8'd100, b: 8'd100, p: 16'h2710, ov: 1'b1, zero: 1'b0, lat: 26};
        run_op(8'd100, 8'd100, 2, 1'b0, lat, p, ov, zero);
        check_result("after_rst", v, lat, p, ov, zero);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, int'($urandom_range(1, 3)), 1'b0, lat, p, ov, zero);
            check_result($sformatf("rand%0d_%0dx%0d", i, ra, rb), model(ra, rb), lat, p, ov, zero);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
